// File: rtl/game_state_ctrl.sv
// Registered game-state controller: synchronised/debounced switches, die edge
// detection, lives tracking and a frame-counted respawn delay.
module game_state_ctrl #(
   parameter int DEB_CYCLES    = 500000,
   parameter int LIVES         = 3,
   parameter int LIVES_W       = 2,
   parameter int RESPAWN_TICKS = 60
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sw_run,
   input  logic               sw_quit,
   input  logic               sw_pause,
   input  logic               die,
   input  logic               frame_tick,
   output logic [2:0]         state,
   output logic [LIVES_W-1:0] lives,
   output logic               respawn,
   output logic               play_rst
);

   localparam int DEB_W = $clog2(DEB_CYCLES + 1);
   localparam int RSP_W = $clog2(RESPAWN_TICKS + 1);
   localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
   localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
   localparam logic [RSP_W-1:0]   RSP_INIT   = RSP_W'(RESPAWN_TICKS);

   typedef enum logic [2:0] {
      ST_RESET   = 3'b000,
      ST_GAME    = 3'b001,
      ST_OVER    = 3'b010,
      ST_PAUSE   = 3'b011,
      ST_RESPAWN = 3'b100
   } state_t;

   // Switch bit order everywhere: [0] run, [1] quit, [2] pause
   logic [2:0]            sync1_q, sync1_d;
   logic [2:0]            sync2_q, sync2_d;
   logic [2:0]            deb_q, deb_d;
   logic [2:0][DEB_W-1:0] cnt_q, cnt_d;

   state_t               state_q, state_d;
   logic [LIVES_W-1:0]   lives_q, lives_d;
   logic [RSP_W-1:0]     rcnt_q, rcnt_d;
   logic                 respawn_q, respawn_d;
   logic                 play_rst_q, play_rst_d;
   logic                 die_q, die_d;

   logic run_on, quit_on, pause_on, die_edge;

   assign run_on   = deb_q[0];
   assign quit_on  = deb_q[1];
   assign pause_on = deb_q[2];

   // A switch is accepted only after DEB_CYCLES consecutive cycles of disagreement
   always_comb begin
      sync1_d = {sw_pause, sw_quit, sw_run};
      sync2_d = sync1_q;
      deb_d   = deb_q;
      cnt_d   = '0;
      for (int k = 0; k < 3; k++) begin
         if (sync2_q[k] != deb_q[k]) begin
            if (cnt_q[k] == DEB_LAST) begin
               deb_d[k] = sync2_q[k];
            end else begin
               cnt_d[k] = cnt_q[k] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      lives_d   = lives_q;
      rcnt_d    = rcnt_q;
      respawn_d = 1'b0;
      die_d     = die;
      die_edge  = die & ~die_q;

      if (!run_on) begin
         state_d = ST_RESET;
         lives_d = LIVES_INIT;
      end else begin
         case (state_q)
            ST_RESET: begin
               lives_d = LIVES_INIT;
               state_d = ST_GAME;
            end
            ST_GAME: begin
               // A death takes precedence over quit/pause seen in the same cycle
               if (die_edge) begin
                  if (lives_q > LIVES_W'(1)) begin
                     lives_d = lives_q - 1'b1;
                     rcnt_d  = RSP_INIT;
                     state_d = ST_RESPAWN;
                  end else begin
                     lives_d = '0;
                     state_d = ST_OVER;
                  end
               end else if (quit_on) begin
                  state_d = ST_OVER;
               end else if (pause_on) begin
                  state_d = ST_PAUSE;
               end
            end
            ST_PAUSE: begin
               if (quit_on) begin
                  state_d = ST_OVER;
               end else if (!pause_on) begin
                  state_d = ST_GAME;
               end
            end
            ST_RESPAWN: begin
               if (quit_on) begin
                  state_d = ST_OVER;
               end else if (frame_tick) begin
                  if (rcnt_q <= RSP_W'(1)) begin
                     rcnt_d    = '0;
                     respawn_d = 1'b1;
                     state_d   = ST_GAME;
                  end else begin
                     rcnt_d = rcnt_q - 1'b1;
                  end
               end
            end
            ST_OVER: state_d = ST_OVER;
            default: state_d = ST_RESET;
         endcase
      end

      play_rst_d = (state_d == ST_RESET);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         deb_q      <= '0;
         cnt_q      <= '0;
         state_q    <= ST_RESET;
         lives_q    <= LIVES_INIT;
         rcnt_q     <= '0;
         respawn_q  <= 1'b0;
         play_rst_q <= 1'b1;
         die_q      <= 1'b0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         deb_q      <= deb_d;
         cnt_q      <= cnt_d;
         state_q    <= state_d;
         lives_q    <= lives_d;
         rcnt_q     <= rcnt_d;
         respawn_q  <= respawn_d;
         play_rst_q <= play_rst_d;
         die_q      <= die_d;
      end
   end

   assign state    = state_q;
   assign lives    = lives_q;
   assign respawn  = respawn_q;
   assign play_rst = play_rst_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Scenario bench for game_state_ctrl with DEB_CYCLES=4, RESPAWN_TICKS=3, LIVES=3.
module tb_game_state_ctrl;

   localparam logic [2:0] S_RST   = 3'b000;
   localparam logic [2:0] S_GAME  = 3'b001;
   localparam logic [2:0] S_OVER  = 3'b010;
   localparam logic [2:0] S_PAUSE = 3'b011;
   localparam logic [2:0] S_RESP  = 3'b100;

   logic       clk = 1'b0;
   logic       rst;
   logic       sw_run, sw_quit, sw_pause, die, frame_tick;
   logic [2:0] state;
   logic [1:0] lives;
   logic       respawn, play_rst;

   typedef struct packed {
      logic [2:0] st;
      logic [1:0] lv;
      logic       rsp;
      logic       prst;
   } obs_t;

   obs_t sb[$];
   int   n_run  = 0;
   int   n_fail = 0;

   game_state_ctrl #(
      .DEB_CYCLES    (4),
      .LIVES         (3),
      .LIVES_W       (2),
      .RESPAWN_TICKS (3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sw_run     (sw_run),
      .sw_quit    (sw_quit),
      .sw_pause   (sw_pause),
      .die        (die),
      .frame_tick (frame_tick),
      .state      (state),
      .lives      (lives),
      .respawn    (respawn),
      .play_rst   (play_rst)
   );

   always #5 clk = ~clk;

   function automatic obs_t mk(logic [2:0] s, logic [1:0] l, logic r);
      return {s, l, r, (s == S_RST)};
   endfunction

   function automatic obs_t obs();
      return {state, lives, respawn, play_rst};
   endfunction

   function automatic string fmt(obs_t o);
      return $sformatf("st=%b lv=%0d rsp=%b prst=%b", o.st, o.lv, o.rsp, o.prst);
   endfunction

   task automatic test_reset();
      obs_t e, a;
      rst = 1'b0; sw_run = 1'b0; sw_quit = 1'b0; sw_pause = 1'b0;
      die = 1'b0; frame_tick = 1'b0;
      for (int i = 0; i < 2; i++) begin
         sb.push_back(mk(S_RST, 2'd3, 1'b0));
         @(posedge clk); #1;
         e = sb.pop_front(); a = obs(); n_run++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL reset[%0d]: got %s want %s", i, fmt(a), fmt(e));
         end
      end
      rst = 1'b1;
   endtask

   task automatic test_bounce();
      obs_t e, a;
      for (int i = 0; i < 20; i++) begin
         sw_run = i[1];
         sb.push_back(mk(S_RST, 2'd3, 1'b0));
         @(posedge clk); #1;
         e = sb.pop_front(); a = obs(); n_run++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL bounce[%0d]: got %s want %s", i, fmt(a), fmt(e));
         end
      end
   endtask

   task automatic test_startup();
      obs_t e, a;
      rst = 1'b0; sw_run = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         sb.push_back((i < 7) ? mk(S_RST, 2'd3, 1'b0) : mk(S_GAME, 2'd3, 1'b0));
         @(posedge clk); #1;
         e = sb.pop_front(); a = obs(); n_run++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL startup[%0d]: got %s want %s", i, fmt(a), fmt(e));
         end
      end
   endtask

   task automatic test_die_respawn();
      obs_t e, a;
      for (int i = 0; i < 8; i++) begin
         die        = (i == 0);
         frame_tick = (i == 1) || (i == 3) || (i == 5) || (i == 6);
         if (i < 5)       sb.push_back(mk(S_RESP, 2'd2, 1'b0));
         else if (i == 5) sb.push_back(mk(S_GAME, 2'd2, 1'b1));
         else             sb.push_back(mk(S_GAME, 2'd2, 1'b0));
         @(posedge clk); #1;
         e = sb.pop_front(); a = obs(); n_run++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL die_respawn[%0d]: got %s want %s", i, fmt(a), fmt(e));
         end
      end
      die = 1'b0; frame_tick = 1'b0;
   endtask

   task automatic test_lives_to_over();
      obs_t e, a;
      for (int i = 0; i < 36; i++) begin
         die        = (i == 0) || (i == 5);
         frame_tick = (i >= 1) && (i <= 3);
         if (i == 6)  begin sw_pause = 1'b1; sw_quit = 1'b1; end
         if (i == 14) begin sw_pause = 1'b0; sw_quit = 1'b0; end
         if (i == 22) sw_run = 1'b0;
         if (i == 29) sw_run = 1'b1;
         if (i < 3)       sb.push_back(mk(S_RESP, 2'd1, 1'b0));
         else if (i == 3) sb.push_back(mk(S_GAME, 2'd1, 1'b1));
         else if (i == 4) sb.push_back(mk(S_GAME, 2'd1, 1'b0));
         else if (i < 28) sb.push_back(mk(S_OVER, 2'd0, 1'b0));
         else if (i < 35) sb.push_back(mk(S_RST,  2'd3, 1'b0));
         else             sb.push_back(mk(S_GAME, 2'd3, 1'b0));
         @(posedge clk); #1;
         e = sb.pop_front(); a = obs(); n_run++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL lives_to_over[%0d]: got %s want %s", i, fmt(a), fmt(e));
         end
      end
      die = 1'b0; frame_tick = 1'b0;
   endtask

   task automatic test_die_vs_pause();
      obs_t e, a;
      for (int i = 0; i < 32; i++) begin
         die        = (i == 6) || (i == 11);
         frame_tick = (i >= 7) && (i <= 9);
         if (i == 0)  sw_pause = 1'b1;
         if (i == 11) sw_quit  = 1'b1;
         if (i == 18) begin sw_run = 1'b0; sw_quit = 1'b0; sw_pause = 1'b0; end
         if (i == 25) sw_run = 1'b1;
         if (i < 6)       sb.push_back(mk(S_GAME,  2'd3, 1'b0));
         else if (i < 9)  sb.push_back(mk(S_RESP,  2'd2, 1'b0));
         else if (i == 9) sb.push_back(mk(S_GAME,  2'd2, 1'b1));
         else if (i < 17) sb.push_back(mk(S_PAUSE, 2'd2, 1'b0));
         else if (i < 24) sb.push_back(mk(S_OVER,  2'd2, 1'b0));
         else if (i < 31) sb.push_back(mk(S_RST,   2'd3, 1'b0));
         else             sb.push_back(mk(S_GAME,  2'd3, 1'b0));
         @(posedge clk); #1;
         e = sb.pop_front(); a = obs(); n_run++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL die_vs_pause[%0d]: got %s want %s", i, fmt(a), fmt(e));
         end
      end
      die = 1'b0; frame_tick = 1'b0;
   endtask

   task automatic test_die_held();
      obs_t e, a;
      for (int i = 0; i < 8; i++) begin
         die        = (i != 6);
         frame_tick = (i >= 1) && (i <= 3);
         if (i < 3)       sb.push_back(mk(S_RESP, 2'd2, 1'b0));
         else if (i == 3) sb.push_back(mk(S_GAME, 2'd2, 1'b1));
         else if (i < 7)  sb.push_back(mk(S_GAME, 2'd2, 1'b0));
         else             sb.push_back(mk(S_RESP, 2'd1, 1'b0));
         @(posedge clk); #1;
         e = sb.pop_front(); a = obs(); n_run++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL die_held[%0d]: got %s want %s", i, fmt(a), fmt(e));
         end
      end
      frame_tick = 1'b0;
   endtask

   task automatic test_async_reset();
      obs_t e, a;
      #2;
      rst = 1'b0;
      sb.push_back(mk(S_RST, 2'd3, 1'b0));
      #1;
      e = sb.pop_front(); a = obs(); n_run++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL async_reset_now: got %s want %s", fmt(a), fmt(e));
      end
      sb.push_back(mk(S_RST, 2'd3, 1'b0));
      @(posedge clk); #1;
      e = sb.pop_front(); a = obs(); n_run++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL async_reset_held: got %s want %s", fmt(a), fmt(e));
      end
      die = 1'b0;
      rst = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         sb.push_back((i < 7) ? mk(S_RST, 2'd3, 1'b0) : mk(S_GAME, 2'd3, 1'b0));
         @(posedge clk); #1;
         e = sb.pop_front(); a = obs(); n_run++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL async_restart[%0d]: got %s want %s", i, fmt(a), fmt(e));
         end
      end
   endtask

   initial begin
      rst = 1'b0;
      sw_run = 1'b0; sw_quit = 1'b0; sw_pause = 1'b0;
      die = 1'b0; frame_tick = 1'b0;
      test_reset();
      test_bounce();
      test_startup();
      test_die_respawn();
      test_lives_to_over();
      test_die_vs_pause();
      test_die_held();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
